// File: rtl/bus_pkg.sv
// bus_pkg: constants and helpers shared by the ram_responder slice.
//   MMIO_BASE_HI_DEFAULT : default upper address half of the MMIO window
//   OFS_*                : MMIO register offsets (ram_addr_i[11:0])
//   mmio_reg_e           : decoded MMIO register selector
//   decode_offset()      : maps an MMIO offset to mmio_reg_e
//   merge_lanes()        : byte-lane write merge (sel bit n covers [8n+7:8n])
package bus_pkg;

   localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'h1FAF;

   localparam logic [11:0] OFS_LED     = 12'h000;
   localparam logic [11:0] OFS_COUNT   = 12'h004;
   localparam logic [11:0] OFS_COMPARE = 12'h008;
   localparam logic [11:0] OFS_STATUS  = 12'h00C;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_LED,
      REG_COUNT,
      REG_COMPARE,
      REG_STATUS
   } mmio_reg_e;

   function automatic mmio_reg_e decode_offset(input logic [11:0] ofs);
      mmio_reg_e r;
      case (ofs)
         OFS_LED:     r = REG_LED;
         OFS_COUNT:   r = REG_COUNT;
         OFS_COMPARE: r = REG_COMPARE;
         OFS_STATUS:  r = REG_STATUS;
         default:     r = REG_NONE;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] mask;
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      return (new_word & mask) | (old_word & ~mask);
   endfunction

endpackage

// File: rtl/ram_responder_timer.sv
// ram_responder_timer: free-running COUNT with COMPARE match and a sticky
// pending flag.
//   clk_i, rst_i       : clock, async active-high reset
//   count_we_i         : write COUNT this cycle (lanes from sel_i)
//   compare_we_i       : write COMPARE this cycle
//   status_we_i        : write STATUS this cycle (bit0 = 1 clears pending)
//   sel_i, wdata_i     : byte lanes and write data
//   count_o, compare_o : register contents for readback
//   pending_o          : sticky match flag (registered)
module ram_responder_timer
   import bus_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic        status_we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        pending_o
);

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        pending_q;
   logic        match;
   logic        clear;

   // COMPARE == 0 is the "timer off" setting, so it never matches.
   assign match = (count_q == compare_q) && (compare_q != 32'h0);
   assign clear = status_we_i & sel_i[0] & wdata_i[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
         pending_q <= 1'b0;
      end else begin
         // Unwritten lanes keep the pre-increment value, not count+1.
         if (count_we_i)
            count_q <= merge_lanes(count_q, wdata_i, sel_i);
         else
            count_q <= count_q + 32'd1;

         if (compare_we_i)
            compare_q <= merge_lanes(compare_q, wdata_i, sel_i);

         // A simultaneous match wins over a software clear.
         if (match)
            pending_q <= 1'b1;
         else if (clear)
            pending_q <= 1'b0;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/ram_responder.sv
// ram_responder: word RAM plus a small MMIO block (LED register and an
// optional timer) answering a single-cycle datapath memory port.
//   clk_i, rst_i  : clock, async active-high reset
//   ram_ce_i      : access enable
//   ram_we_i      : 1 = write, 0 = read
//   ram_sel_i     : byte lane enables
//   ram_addr_i    : byte address; [31:16]==MMIO_BASE_HI selects MMIO
//   ram_wdata_i   : write data
//   ram_rdata_o   : combinational read data, 0 when not reading
//   int_o         : timer pending flag
//   led_o         : LED register
// Build option: define RAM_RESPONDER_TIMER_EN to include COUNT/COMPARE/STATUS
// and the interrupt; otherwise those offsets read 0 and int_o is tied low.
module ram_responder
   import bus_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ram_ce_i,
   input  logic        ram_we_i,
   input  logic [3:0]  ram_sel_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_wdata_i,
   output logic [31:0] ram_rdata_o,
   output logic        int_o,
   output logic [15:0] led_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic          mmio_hit;
   mmio_reg_e     reg_sel;
   logic          wr_req;
   logic          rd_req;
   logic          ram_wr;
   logic          led_we;
   logic [15:0]   led_q;
   logic [31:0]   led_merged;
   logic [31:0]   mmio_rdata;
   logic          unused_ok;

   // Upper address bits above the RAM index are dropped, so RAM aliases.
   assign word_idx = ram_addr_i[AW+1:2];
   assign mmio_hit = (ram_addr_i[31:16] == MMIO_BASE_HI);
   assign reg_sel  = decode_offset(ram_addr_i[11:0]);

   // A write with no lanes selected is treated as no access at all.
   assign wr_req = ram_ce_i & ram_we_i & (|ram_sel_i);
   assign rd_req = ram_ce_i & ~ram_we_i;
   assign ram_wr = wr_req & ~mmio_hit;
   assign led_we = wr_req & mmio_hit & (reg_sel == REG_LED);

   assign led_merged = merge_lanes({16'h0, led_q}, ram_wdata_i, ram_sel_i);

   // RAM shares the reset block so writes during reset are dropped, but
   // its contents are never cleared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led_q <= 16'h0;
      end else begin
         if (led_we)
            led_q <= led_merged[15:0];
         if (ram_wr)
            mem[word_idx] <= merge_lanes(mem[word_idx], ram_wdata_i, ram_sel_i);
      end
   end

   assign led_o = led_q;

`ifdef RAM_RESPONDER_TIMER_EN
   logic [31:0] count_w;
   logic [31:0] compare_w;
   logic        pending_w;

   ram_responder_timer u_timer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .count_we_i   (wr_req & mmio_hit & (reg_sel == REG_COUNT)),
      .compare_we_i (wr_req & mmio_hit & (reg_sel == REG_COMPARE)),
      .status_we_i  (wr_req & mmio_hit & (reg_sel == REG_STATUS)),
      .sel_i        (ram_sel_i),
      .wdata_i      (ram_wdata_i),
      .count_o      (count_w),
      .compare_o    (compare_w),
      .pending_o    (pending_w)
   );

   assign int_o = pending_w;
`else
   assign int_o = 1'b0;
`endif

   always_comb begin
      mmio_rdata = 32'h0;
      case (reg_sel)
         REG_LED:     mmio_rdata = {16'h0, led_q};
`ifdef RAM_RESPONDER_TIMER_EN
         REG_COUNT:   mmio_rdata = count_w;
         REG_COMPARE: mmio_rdata = compare_w;
         REG_STATUS:  mmio_rdata = {31'h0, pending_w};
`endif
         default:     mmio_rdata = 32'h0;
      endcase
   end

   always_comb begin
      ram_rdata_o = 32'h0;
      if (rd_req)
         ram_rdata_o = mmio_hit ? mmio_rdata : mem[word_idx];
   end

   assign unused_ok = ^{ram_addr_i, led_merged[31:16], ram_wdata_i};

endmodule
